// File: rtl/nand_gate_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nand_gate_bank_pkg
// Description : Shared constants and elaboration checks for Flip Chip successors
// Revision    : 1.0 - initial release
// ============================================================================

// Stops elaboration when a parameter falls outside its legal range.
`ifndef FC_PARAM_CHECK
`define FC_PARAM_CHECK(LBL, COND, MSG) if (!(COND)) begin : LBL $fatal(1, MSG); end
`endif

package nand_gate_bank_pkg;

  // NAND outputs and delay stages idle at logic high.
  localparam logic IDLE_LVL = 1'b1;

  // Glitch-filter counter width: max($clog2(filter), 1).
  function automatic int cnt_width(input int filter);
    return (filter > 1) ? $clog2(filter) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nand_chan.sv
`default_nettype none
// ============================================================================
// Module      : nand_chan
// Description : One masked NAND channel with delay line, glitch filter and
//               change pulse
// Revision    : 1.0 - initial release
// ============================================================================

module nand_chan
  import nand_gate_bank_pkg::*;
#(
  parameter int                INPUTS  = 8,
  parameter logic [INPUTS-1:0] MASK    = '1,
  parameter int                DELAY   = 1,
  parameter int                FILTER  = 0,
  parameter logic              FILT_ON = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INPUTS-1:0] i_in,
  output logic              o_out,
  output logic              o_chg
);

  logic             w_raw;
  logic [DELAY-1:0] r_stage;
  logic [DELAY-1:0] w_stage_next;
  logic             w_out;
  logic             w_out_next;
  logic             r_chg;

  // Unused pins read as 1 so they never pull the NAND output high.
  assign w_raw = ~&(i_in | ~MASK);

  always_comb begin
    w_stage_next    = '0;
    w_stage_next[0] = w_raw;
    for (int k = 1; k < DELAY; k++) begin
      w_stage_next[k] = r_stage[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage <= {DELAY{IDLE_LVL}};
    end else begin
      r_stage <= w_stage_next;
    end
  end

  if ((FILTER > 0) && FILT_ON) begin : g_filt
    localparam int               CNT_W    = cnt_width(FILTER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_out;

    // Any return of the last stage to the current output restarts the count.
    always_comb begin
      w_out_next = r_out;
      w_cnt_next = '0;
      if (r_stage[DELAY-1] != r_out) begin
        if (r_cnt == CNT_LAST) begin
          w_out_next = r_stage[DELAY-1];
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_out <= IDLE_LVL;
        r_cnt <= '0;
      end else begin
        r_out <= w_out_next;
        r_cnt <= w_cnt_next;
      end
    end

    assign w_out = r_out;
  end else begin : g_direct
    assign w_out      = r_stage[DELAY-1];
    assign w_out_next = w_stage_next[DELAY-1];
  end

  // Compare the value the output is about to take with its present value so
  // the pulse lines up with the cycle the new value first appears.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chg <= 1'b0;
    end else begin
      r_chg <= w_out_next ^ w_out;
    end
  end

  assign o_out = w_out;
  assign o_chg = r_chg;

endmodule

`default_nettype wire

// File: rtl/nand_gate_bank.sv
`default_nettype none
// ============================================================================
// Module      : nand_gate_bank
// Description : Bank of GATES masked, delayed, optionally filtered NAND
//               channels plus constant tie-high outputs
// Revision    : 1.0 - initial release
// ============================================================================

module nand_gate_bank
  import nand_gate_bank_pkg::*;
#(
  parameter int                      GATES   = 3,
  parameter int                      INPUTS  = 8,
  parameter logic [GATES*INPUTS-1:0] IN_MASK = '1,
  parameter int                      DELAY   = 1,
  parameter int                      FILTER  = 0,
  parameter logic [GATES-1:0]        FILT_EN = '1,
  parameter int                      HIGHS   = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [GATES*INPUTS-1:0]              in,
  output logic [GATES-1:0]                     out,
  output logic [GATES-1:0]                     chg,
  output logic [((HIGHS > 0) ? HIGHS : 1)-1:0] hi
);

  localparam int HI_W = (HIGHS > 0) ? HIGHS : 1;

  `FC_PARAM_CHECK(g_chk_gates,  GATES >= 1,  "nand_gate_bank: GATES must be >= 1")
  `FC_PARAM_CHECK(g_chk_inputs, INPUTS >= 2, "nand_gate_bank: INPUTS must be >= 2")
  `FC_PARAM_CHECK(g_chk_delay,  DELAY >= 1,  "nand_gate_bank: DELAY must be >= 1")
  `FC_PARAM_CHECK(g_chk_filter, FILTER >= 0, "nand_gate_bank: FILTER must be >= 0")
  `FC_PARAM_CHECK(g_chk_highs,  HIGHS >= 0,  "nand_gate_bank: HIGHS must be >= 0")

  for (genvar g = 0; g < GATES; g++) begin : g_chan
    nand_chan #(
      .INPUTS  (INPUTS),
      .MASK    (IN_MASK[g*INPUTS +: INPUTS]),
      .DELAY   (DELAY),
      .FILTER  (FILTER),
      .FILT_ON (FILT_EN[g])
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .i_in  (in[g*INPUTS +: INPUTS]),
      .o_out (out[g]),
      .o_chg (chg[g])
    );
  end

  // Tie-highs are not registered, so they stay high through reset.
  assign hi = {HI_W{IDLE_LVL}};

endmodule

`default_nettype wire

// File: tb/tb_nand_gate_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_nand_gate_bank
// Description : Scoreboard bench for three nand_gate_bank configurations
// Revision    : 1.0 - initial release
// ============================================================================

module tb_nand_gate_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] in_a, in_b, in_c;
  logic [2:0]  out_a, chg_a, out_b, chg_b, out_c, chg_c;
  logic [1:0]  hi_a, hi_b, hi_c;

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] sb_q[$];
  logic [2:0]  mh [3][8];
  logic [2:0]  mo [3];
  logic [23:0] cur_a, cur_b, cur_c;

  always #5 clk = ~clk;

  // A: DELAY=3, ch0 bit7 unused, ch2 fully masked.
  nand_gate_bank #(
    .GATES(3), .INPUTS(8), .IN_MASK(24'h00FF7F), .DELAY(3),
    .FILTER(0), .FILT_EN(3'b111), .HIGHS(2)
  ) u_dut_a (
    .clk(clk), .rst(rst), .in(in_a), .out(out_a), .chg(chg_a), .hi(hi_a)
  );

  // B: DELAY=1, FILTER=4 on channel 1 only.
  nand_gate_bank #(
    .GATES(3), .INPUTS(8), .IN_MASK(24'hFFFFFF), .DELAY(1),
    .FILTER(4), .FILT_EN(3'b010), .HIGHS(2)
  ) u_dut_b (
    .clk(clk), .rst(rst), .in(in_b), .out(out_b), .chg(chg_b), .hi(hi_b)
  );

  // C: all defaults.
  nand_gate_bank u_dut_c (
    .clk(clk), .rst(rst), .in(in_c), .out(out_c), .chg(chg_c), .hi(hi_c)
  );

  function automatic logic [23:0] observe();
    return {hi_a, hi_b, hi_c, out_a, chg_a, out_b, chg_b, out_c, chg_c};
  endfunction

  // A channel output is high when any of its used inputs is low.
  function automatic logic [2:0] raw_of(input logic [23:0] v, input logic [23:0] m);
    logic [2:0] r;
    r = 3'b000;
    for (int g = 0; g < 3; g++)
      for (int b = 0; b < 8; b++)
        if (m[g*8+b] && !v[g*8+b]) r[g] = 1'b1;
    return r;
  endfunction

  // History model: mh[d][k] is the raw value sampled k edges ago.
  task automatic model_step(input int d, input logic [23:0] v, input logic r,
                            output logic [5:0] oc);
    int         dl;
    int         fl;
    logic [2:0] fen;
    logic [23:0] m;
    logic [2:0] o;
    logic       full;
    case (d)
      0:       begin dl = 3; fl = 0; fen = 3'b111; m = 24'h00FF7F; end
      1:       begin dl = 1; fl = 4; fen = 3'b010; m = 24'hFFFFFF; end
      default: begin dl = 1; fl = 0; fen = 3'b111; m = 24'hFFFFFF; end
    endcase
    if (r) begin
      for (int k = 0; k < 8; k++) mh[d][k] = 3'b111;
      mo[d] = 3'b111;
      oc    = {3'b111, 3'b000};
    end else begin
      for (int k = 7; k > 0; k--) mh[d][k] = mh[d][k-1];
      mh[d][0] = raw_of(v, m);
      for (int g = 0; g < 3; g++) begin
        if (fl > 0 && fen[g]) begin
          full = 1'b1;
          for (int k = dl; k < dl + fl; k++)
            if (mh[d][k][g] == mo[d][g]) full = 1'b0;
          o[g] = full ? ~mo[d][g] : mo[d][g];
        end else begin
          o[g] = mh[d][dl-1][g];
        end
      end
      oc    = {o, o ^ mo[d]};
      mo[d] = o;
    end
  endtask

  // Drive one cycle of stimulus, push its expected result, advance one edge.
  task automatic cycle(input logic [23:0] a, input logic [23:0] b,
                       input logic [23:0] c, input logic r);
    logic [5:0] ea, eb, ec;
    in_a = a; in_b = b; in_c = c; rst = r;
    model_step(0, a, r, ea);
    model_step(1, b, r, eb);
    model_step(2, c, r, ec);
    sb_q.push_back({6'b111111, ea, eb, ec});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [23:0] got, exp_v;
    cur_a = '1; cur_b = '1; cur_c = '1;
    for (int k = 0; k < 3; k++) begin
      cycle(cur_a, cur_b, cur_c, 1'b1);
      got = observe(); exp_v = sb_q.pop_front(); n_tests++;
      if (got !== exp_v) begin
        n_fail++; $display("FAIL reset_hold[%0d]: got %h, expected %h", k, got, exp_v);
      end
      n_tests++;
      if ({out_c, chg_c, hi_a, hi_b, hi_c} !== {3'b111, 3'b000, 6'b111111}) begin
        n_fail++; $display("FAIL reset_state[%0d]: got %b, expected 111000111111", k,
                           {out_c, chg_c, hi_a, hi_b, hi_c});
      end
    end
    for (int k = 1; k <= 8; k++) begin
      cycle(cur_a, cur_b, cur_c, 1'b0);
      got = observe(); exp_v = sb_q.pop_front(); n_tests++;
      if (got !== exp_v) begin
        n_fail++; $display("FAIL reset_release[%0d]: got %h, expected %h", k, got, exp_v);
      end
      if (k <= 2) begin
        n_tests++;
        if ({out_c, chg_c} !== {3'b000, (k == 1) ? 3'b111 : 3'b000}) begin
          n_fail++; $display("FAIL release_c[%0d]: got %b, expected %b", k, {out_c, chg_c},
                             {3'b000, (k == 1) ? 3'b111 : 3'b000});
        end
      end
    end
  endtask

  task automatic test_delay_and_mask();
    logic [23:0] got, exp_v;
    cur_a = 24'hFFFFFF & ~24'h000020;
    for (int k = 1; k <= 6; k++) begin
      cycle(cur_a, cur_b, cur_c, 1'b0);
      got = observe(); exp_v = sb_q.pop_front(); n_tests++;
      if (got !== exp_v) begin
        n_fail++; $display("FAIL delay_sb[%0d]: got %h, expected %h", k, got, exp_v);
      end
      n_tests++;
      if ({out_a[0], chg_a[0]} !== {(k >= 3), (k == 3)}) begin
        n_fail++; $display("FAIL delay3_ch0[%0d]: got %b, expected %b", k,
                           {out_a[0], chg_a[0]}, {(k >= 3), (k == 3)});
      end
    end
    cur_a = '1;
    for (int k = 1; k <= 5; k++) begin
      cycle(cur_a, cur_b, cur_c, 1'b0);
      got = observe(); exp_v = sb_q.pop_front(); n_tests++;
      if (got !== exp_v) begin
        n_fail++; $display("FAIL delay_restore[%0d]: got %h, expected %h", k, got, exp_v);
      end
    end
    for (int k = 1; k <= 6; k++) begin
      cur_a[7]  = k[0];
      cur_a[20] = ~k[0];
      cycle(cur_a, cur_b, cur_c, 1'b0);
      got = observe(); exp_v = sb_q.pop_front(); n_tests++;
      if (got !== exp_v) begin
        n_fail++; $display("FAIL mask_sb[%0d]: got %h, expected %h", k, got, exp_v);
      end
      n_tests++;
      if ({out_a[0], out_a[2]} !== 2'b00) begin
        n_fail++; $display("FAIL masked_pins[%0d]: got %b, expected 00", k, {out_a[0], out_a[2]});
      end
    end
    cur_a = '1;
  endtask

  task automatic test_filter();
    logic [23:0] got, exp_v;
    for (int k = 1; k <= 9; k++) begin
      cur_b = (k <= 3) ? (24'hFFFFFF & ~24'h000202) : 24'hFFFFFF;
      cycle(cur_a, cur_b, cur_c, 1'b0);
      got = observe(); exp_v = sb_q.pop_front(); n_tests++;
      if (got !== exp_v) begin
        n_fail++; $display("FAIL glitch_sb[%0d]: got %h, expected %h", k, got, exp_v);
      end
      n_tests++;
      if ({out_b[1], chg_b[1], out_b[0]} !== {2'b00, (k <= 3)}) begin
        n_fail++; $display("FAIL glitch3[%0d]: got %b, expected %b", k,
                           {out_b[1], chg_b[1], out_b[0]}, {2'b00, (k <= 3)});
      end
    end
    cur_b = 24'hFFFFFF & ~24'h000200;
    for (int k = 1; k <= 7; k++) begin
      cycle(cur_a, cur_b, cur_c, 1'b0);
      got = observe(); exp_v = sb_q.pop_front(); n_tests++;
      if (got !== exp_v) begin
        n_fail++; $display("FAIL hold_sb[%0d]: got %h, expected %h", k, got, exp_v);
      end
      n_tests++;
      if ({out_b[1], chg_b[1]} !== {(k >= 5), (k == 5)}) begin
        n_fail++; $display("FAIL hold4[%0d]: got %b, expected %b", k,
                           {out_b[1], chg_b[1]}, {(k >= 5), (k == 5)});
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] got, exp_v;
    cur_b = '1;
    for (int k = 1; k <= 4; k++) begin
      cycle(cur_a, cur_b, cur_c, (k == 4));
      got = observe(); exp_v = sb_q.pop_front(); n_tests++;
      if (got !== exp_v) begin
        n_fail++; $display("FAIL midrst_sb[%0d]: got %h, expected %h", k, got, exp_v);
      end
    end
    n_tests++;
    if ({out_b, chg_b} !== {3'b111, 3'b000}) begin
      n_fail++; $display("FAIL midrst_state: got %b, expected 111000", {out_b, chg_b});
    end
    for (int j = 1; j <= 6; j++) begin
      cycle(cur_a, cur_b, cur_c, 1'b0);
      got = observe(); exp_v = sb_q.pop_front(); n_tests++;
      if (got !== exp_v) begin
        n_fail++; $display("FAIL midrst_rel_sb[%0d]: got %h, expected %h", j, got, exp_v);
      end
      n_tests++;
      if (out_b[1] !== (j < 5)) begin
        n_fail++; $display("FAIL midrst_full_count[%0d]: got %b, expected %b", j, out_b[1], (j < 5));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] got, exp_v;
    cur_c = 24'hFFFFFF & ~24'h010101;
    for (int k = 1; k <= 6; k++) begin
      if (k == 4) cur_c = '1;
      cycle(cur_a, cur_b, cur_c, 1'b0);
      got = observe(); exp_v = sb_q.pop_front(); n_tests++;
      if (got !== exp_v) begin
        n_fail++; $display("FAIL simul_sb[%0d]: got %h, expected %h", k, got, exp_v);
      end
      if (k == 1 || k == 4) begin
        n_tests++;
        if (chg_c !== 3'b111) begin
          n_fail++; $display("FAIL simul_chg[%0d]: got %b, expected 111", k, chg_c);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [23:0] got, exp_v;
    logic        r;
    int          idx;
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        cur_a = '1; cur_b = '1; cur_c = '1;
        idx = $urandom_range(0, 23); cur_a[idx] = 1'b0;
        idx = $urandom_range(0, 23); cur_b[idx] = 1'b0;
        idx = $urandom_range(0, 23); cur_c[idx] = 1'b0;
      end
      r = ($urandom_range(0, 19) == 0);
      cycle(cur_a, cur_b, cur_c, r);
      got = observe(); exp_v = sb_q.pop_front(); n_tests++;
      if (got !== exp_v) begin
        n_fail++; $display("FAIL random[%0d]: got %h, expected %h", k, got, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_delay_and_mask();
    test_filter();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
